discharge_controller: RTL and testbench

- Drain-side counterpart to the recharge saturation counter: models battery consumption by decrementing a charge level at a programmable rate.
- Level saturates at zero; low and empty status flags are raised at thresholds.
- Sits beside the recharge counter in the battery datapath. Recharge loads a level in; this block consumes it.

---
 rtl/discharge_controller_if.sv | 27 ++
 rtl/discharge_controller.sv | 89 ++++++++
 tb/tb_discharge_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/discharge_controller_if.sv
// Bus bundle for the discharge controller: load/run controls in, charge level and status out.
interface discharge_controller_if #(
    parameter int unsigned n  = 9,
    parameter int unsigned pw = 4
) ();
    logic          load;
    logic [n-1:0]  in;
    logic          start;
    logic          stop;
    logic [3:0]    drain;
    logic [pw-1:0] prescale;
    logic [n-1:0]  level;
    logic [1:0]    state;
    logic          low;
    logic          empty;
    logic          tick;

    modport master (
        output load, in, start, stop, drain, prescale,
        input  level, state, low, empty, tick
    );

    modport slave (
        input  load, in, start, stop, drain, prescale,
        output level, state, low, empty, tick
    );
endinterface

// File: rtl/discharge_controller.sv
// Battery drain model: saturating down-counter on the charge level, paced by a
// programmable prescaler, with IDLE/DRAIN/LOW/EMPTY run states.
module discharge_controller #(
    parameter int unsigned n         = 9,
    parameter int unsigned LOW_LEVEL = 32,
    parameter int unsigned pw        = 4
) (
    input logic                   clk,
    input logic                   rst,
    discharge_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRAIN = 2'b01,
        S_LOW   = 2'b10,
        S_EMPTY = 2'b11
    } state_e;

    localparam logic [n-1:0] LOW_TH = n'(LOW_LEVEL);

    state_e        state_q;
    logic [n-1:0]  level_q;
    logic [n-1:0]  level_d;
    logic [pw-1:0] presc_q;
    logic          tick_q;
    logic [n:0]    diff;

    // Subtract one bit wider than the level so a borrow shows up as the MSB.
    always_comb begin
        diff    = {1'b0, level_q} - (n+1)'(bus.drain);
        level_d = diff[n] ? '0 : diff[n-1:0];
    end

    function automatic state_e classify(input logic [n-1:0] l);
        if (l == '0)
            return S_EMPTY;
        else if (l < LOW_TH)
            return S_LOW;
        return S_DRAIN;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            state_q <= S_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (bus.load) begin
                level_q <= bus.in;
                state_q <= S_IDLE;
                presc_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            state_q <= classify(level_q);
                            presc_q <= '0;
                        end
                    end
                    S_DRAIN, S_LOW: begin
                        if (bus.stop) begin
                            state_q <= S_IDLE;
                            presc_q <= '0;
                        // >= so a lowered prescale takes effect at once instead of wrapping.
                        end else if (presc_q >= bus.prescale) begin
                            level_q <= level_d;
                            state_q <= classify(level_d);
                            presc_q <= '0;
                            tick_q  <= 1'b1;
                        end else begin
                            presc_q <= presc_q + pw'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.level = level_q;
    assign bus.state = state_q;
    assign bus.tick  = tick_q;
    assign bus.empty = (level_q == '0);
    assign bus.low   = (level_q < LOW_TH) && (level_q != '0);

endmodule

// File: tb/tb_discharge_controller.sv
// Directed bench for discharge_controller: vector table plus hand sequences for long runs.
module tb_discharge_controller;

    localparam int ST_IDLE  = 0;
    localparam int ST_DRAIN = 1;
    localparam int ST_LOW   = 2;
    localparam int ST_EMPTY = 3;

    logic clk;
    logic rst;

    discharge_controller_if #(.n(9), .pw(4)) bus ();

    discharge_controller #(.n(9), .LOW_LEVEL(32), .pw(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    typedef struct {
        string name;
        bit    load;
        int    in;
        bit    start;
        bit    stop;
        int    drain;
        int    prescale;
        int    e_level;
        int    e_state;
        bit    e_low;
        bit    e_empty;
        bit    e_tick;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, bit ld, int vin, bit st, bit sp, int dr, int pr,
                                int lv, int stt, bit lo, bit em, bit tk);
        vec_t v;
        v.name = nm; v.load = ld; v.in = vin; v.start = st; v.stop = sp;
        v.drain = dr; v.prescale = pr; v.e_level = lv; v.e_state = stt;
        v.e_low = lo; v.e_empty = em; v.e_tick = tk;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ld, input int vin, input bit st, input bit sp,
                         input int dr, input int pr);
        bus.load     = ld;
        bus.in       = 9'(vin);
        bus.start    = st;
        bus.stop     = sp;
        bus.drain    = 4'(dr);
        bus.prescale = 4'(pr);
    endtask

    task automatic chk_all(input string nm, input int lv, input int stt, input bit tk);
        chk({nm, ".level"}, int'(bus.level), lv);
        chk({nm, ".state"}, int'(bus.state), stt);
        chk({nm, ".tick"},  int'(bus.tick), int'(tk));
        chk({nm, ".low"},   int'(bus.low),   int'((lv < 32) && (lv != 0)));
        chk({nm, ".empty"}, int'(bus.empty), int'(lv == 0));
    endtask

    // One full prescale period: level held with tick low, then one step with tick high.
    task automatic period(input string nm, input int edges, input int lv_before, input int lv_after);
        for (int i = 1; i < edges; i++) begin
            edge_step();
            chk({nm, ".hold_level"}, int'(bus.level), lv_before);
            chk({nm, ".hold_tick"},  int'(bus.tick), 0);
        end
        edge_step();
        chk({nm, ".step_level"}, int'(bus.level), lv_after);
        chk({nm, ".step_tick"},  int'(bus.tick), 1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Saturating drain, one-cycle tick, load-beats-start, stop-beats-tick.
        vecs.push_back(mk("t2_load",   1,  5, 0, 0, 7, 3,  5, ST_IDLE,  1, 0, 0));
        vecs.push_back(mk("t2_start",  0,  0, 1, 0, 7, 3,  5, ST_LOW,   1, 0, 0));
        vecs.push_back(mk("t2_e1",     0,  0, 0, 0, 7, 3,  5, ST_LOW,   1, 0, 0));
        vecs.push_back(mk("t2_e2",     0,  0, 0, 0, 7, 3,  5, ST_LOW,   1, 0, 0));
        vecs.push_back(mk("t2_e3",     0,  0, 0, 0, 7, 3,  5, ST_LOW,   1, 0, 0));
        vecs.push_back(mk("t2_e4",     0,  0, 0, 0, 7, 3,  0, ST_EMPTY, 0, 1, 1));
        vecs.push_back(mk("t2_e5",     0,  0, 0, 0, 7, 3,  0, ST_EMPTY, 0, 1, 0));
        vecs.push_back(mk("t2_stopE",  0,  0, 0, 1, 7, 3,  0, ST_EMPTY, 0, 1, 0));
        vecs.push_back(mk("t4_ldst",   1, 50, 1, 0, 5, 0, 50, ST_IDLE,  0, 0, 0));
        vecs.push_back(mk("t4_start",  0,  0, 1, 0, 5, 0, 50, ST_DRAIN, 0, 0, 0));
        vecs.push_back(mk("t4_tick",   0,  0, 0, 0, 5, 0, 45, ST_DRAIN, 0, 0, 1));
        vecs.push_back(mk("t4_stop",   0,  0, 0, 1, 5, 0, 45, ST_IDLE,  0, 0, 0));
        vecs.push_back(mk("t4_idle",   0,  0, 0, 0, 5, 0, 45, ST_IDLE,  0, 0, 0));
        vecs.push_back(mk("t4_exact",  1, 10, 0, 0, 10, 0, 10, ST_IDLE, 1, 0, 0));
        vecs.push_back(mk("t4_exst",   0,  0, 1, 0, 10, 0, 10, ST_LOW,  1, 0, 0));
        vecs.push_back(mk("t4_exdr",   0,  0, 0, 0, 10, 0,  0, ST_EMPTY, 0, 1, 1));
        vecs.push_back(mk("t4_zero",   1, 33, 0, 0, 0, 0, 33, ST_IDLE,  0, 0, 0));
        vecs.push_back(mk("t4_zst",    0,  0, 1, 0, 0, 0, 33, ST_DRAIN, 0, 0, 0));
        vecs.push_back(mk("t4_ztick",  0,  0, 0, 0, 0, 0, 33, ST_DRAIN, 0, 0, 1));
        vecs.push_back(mk("t4_1tolow", 0,  0, 0, 0, 2, 0, 31, ST_LOW,   1, 0, 1));

        edge_step();
        edge_step();
        rst = 1'b0;
        chk_all("reset", 0, ST_IDLE, 0);

        // Test 1: drain by 1 each edge from 100 down to empty.
        drive(1, 100, 0, 0, 1, 0);
        edge_step();
        chk_all("t1_load", 100, ST_IDLE, 0);
        drive(0, 0, 1, 0, 1, 0);
        edge_step();
        chk_all("t1_start", 100, ST_DRAIN, 0);
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 100; k++) begin
            int lv;
            lv = 100 - k;
            edge_step();
            chk("t1_level", int'(bus.level), lv);
            chk("t1_tick", int'(bus.tick), 1);
            if (lv == 31 || lv == 32 || lv == 0 || lv == 1)
                chk_all($sformatf("t1_at%0d", lv), lv,
                        (lv == 0) ? ST_EMPTY : (lv < 32) ? ST_LOW : ST_DRAIN, 1);
        end
        for (int k = 0; k < 4; k++) begin
            edge_step();
            chk_all("t1_after", 0, ST_EMPTY, 0);
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].in, vecs[i].start, vecs[i].stop,
                  vecs[i].drain, vecs[i].prescale);
            edge_step();
            chk({vecs[i].name, ".level"}, int'(bus.level), vecs[i].e_level);
            chk({vecs[i].name, ".state"}, int'(bus.state), vecs[i].e_state);
            chk({vecs[i].name, ".low"},   int'(bus.low),   int'(vecs[i].e_low));
            chk({vecs[i].name, ".empty"}, int'(bus.empty), int'(vecs[i].e_empty));
            chk({vecs[i].name, ".tick"},  int'(bus.tick),  int'(vecs[i].e_tick));
        end

        // Test 3: pause and resume.
        drive(1, 200, 0, 0, 10, 1);
        edge_step();
        drive(0, 0, 1, 0, 10, 1);
        edge_step();
        chk_all("t3_start", 200, ST_DRAIN, 0);
        drive(0, 0, 0, 0, 10, 1);
        period("t3_p1", 2, 200, 190);
        period("t3_p2", 2, 190, 180);
        period("t3_p3", 2, 180, 170);
        drive(0, 0, 0, 1, 10, 1);
        edge_step();
        chk_all("t3_stop", 170, ST_IDLE, 0);
        drive(0, 0, 0, 0, 10, 1);
        for (int k = 0; k < 10; k++) begin
            edge_step();
            chk("t3_paused", int'(bus.level), 170);
        end
        drive(0, 0, 1, 0, 10, 1);
        edge_step();
        chk_all("t3_resume", 170, ST_DRAIN, 0);
        drive(0, 0, 0, 0, 10, 1);
        period("t3_p4", 2, 170, 160);

        // Test 5: reset mid-drain, start on empty, load recovers.
        drive(1, 300, 0, 0, 1, 15);
        edge_step();
        drive(0, 0, 1, 0, 1, 15);
        edge_step();
        drive(0, 0, 0, 0, 1, 15);
        edge_step();
        chk_all("t5_running", 300, ST_DRAIN, 0);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        chk_all("t5_reset", 0, ST_IDLE, 0);
        drive(0, 0, 1, 0, 1, 15);
        edge_step();
        chk_all("t5_start", 0, ST_EMPTY, 0);
        edge_step();
        chk_all("t5_start2", 0, ST_EMPTY, 0);
        drive(1, 40, 0, 0, 1, 15);
        edge_step();
        chk_all("t5_load", 40, ST_IDLE, 0);

        // Test 6: slow drain, then prescale lowered mid-count.
        drive(1, 511, 0, 0, 15, 15);
        edge_step();
        drive(0, 0, 1, 0, 15, 15);
        edge_step();
        chk_all("t6_start", 511, ST_DRAIN, 0);
        drive(0, 0, 0, 0, 15, 15);
        period("t6_p1", 16, 511, 496);
        period("t6_p2", 16, 496, 481);
        for (int k = 0; k < 9; k++) begin
            edge_step();
            chk("t6_count", int'(bus.level), 481);
        end
        drive(0, 0, 0, 0, 15, 2);
        period("t6_fast", 1, 481, 466);
        period("t6_q1", 3, 466, 451);
        period("t6_q2", 3, 451, 436);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
